lcd_bus_arbiter: RTL and testbench
==================================

Name: lcd_bus_arbiter

Overview:
Owns the character-LCD bus (LCMEN/LCMRS/LCMRW/LCMData, HD44780-style, write-only). After reset it runs the power-up init sequence autonomously. It then shares the bus between two requesters, e.g. the keypad-echo writer and a status/refresh writer, using round-robin arbitration. Each accepted byte becomes a correctly timed write cycle (setup, EN pulse, execution hold), so requesters never drive the LCD pins themselves.

Parameters:
SETUP_CYC, 4, cycles RS/data are stable with EN=0 before the EN pulse (min 1)
PULSE_CYC, 12, cycles EN=1 (min 1)
HOLD_CYC, 2500, cycles after EN falls before the bus is free again (normal command/data execution time)
CLEAR_CYC, 82000, hold cycles used instead of HOLD_CYC for Clear (0x01) and Return Home (0x02/0x03) when RS=0
PWRUP_CYC, 750000, idle wait after reset before the first init write
CNT_W, 20, delay counter width; must hold max(all *_CYC)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 write request; level, held until ack0
rs0  in  1  requester 0 register select (0=command, 1=data)
data0  in  8  requester 0 byte
ack0  out  1  one-cycle pulse: requester 0 byte accepted
req1  in  1  requester 1 write request
rs1  in  1  requester 1 register select
data1  in  8  requester 1 byte
ack1  out  1  one-cycle pulse: requester 1 byte accepted
ready  out  1  init sequence complete; requests are now served
busy  out  1  1 when a write cycle or init is in progress
LCMEN  out  1  LCD enable
LCMRS  out  1  LCD register select
LCMRW  out  1  LCD read/write; constant 0
LCMData  out  8  LCD data bus

Behaviour:
- Reset (rst=1 on a clk edge): all outputs are registered. LCMEN=0, LCMRS=0, LCMRW=0, LCMData=0, ack0=ack1=0, ready=0, busy=1. State goes to PWRUP, delay counter=0, init index=0, last_grant=1 (requester 0 wins the first tie). A reset in the middle of any cycle aborts it immediately and restarts init. An aborted request is not acked.
- States: PWRUP, IDLE, SETUP, PULSE, HOLD.
- PWRUP: count PWRUP_CYC cycles, then load init byte 0 (RS=0) and go to SETUP.
- Init bytes, in order, each RS=0: 0x38, 0x0E, 0x01, 0x06. Each runs the full SETUP/PULSE/HOLD cycle. 0x01 uses CLEAR_CYC.
- After the 4th HOLD completes: ready=1, busy=0, go to IDLE. ready stays 1 until the next reset.
- IDLE with ready=1:
  - If any req is high, select a requester. If both are high, pick the one not equal to last_grant; otherwise pick the one requesting.
  - On that edge: latch rs/data into LCMRS/LCMData, update last_grant, set busy=1, go to SETUP.
  - ackN=1 for exactly the next cycle.
- Requests are ignored while ready=0 or state≠IDLE. They are never queued beyond the level itself.
- If req drops before ack, nothing is written. Inputs are sampled only on the acceptance edge; later changes to rsN/dataN have no effect.
- SETUP: EN=0 for SETUP_CYC cycles, then PULSE.
- PULSE: EN=1 for PULSE_CYC cycles, then HOLD.
- HOLD: EN=0 for HOLD_CYC cycles, or CLEAR_CYC when RS=0 and data∈{0x01,0x02,0x03}; then IDLE with busy=0.
- LCMRS/LCMData remain stable from SETUP entry through the end of HOLD and keep that value in IDLE.
- Timing: the first cycle with busy=0 and state IDLE follows the last HOLD cycle. The acceptance-to-next-acceptance minimum is 1+SETUP_CYC+PULSE_CYC+hold cycles.
- If both requesters keep req high continuously, grants strictly alternate 0,1,0,1…
- ack0 and ack1 are never asserted together.
- Counter: compares against (N-1) and resets to 0 on each state change. No wrap; CNT_W must cover all parameters.

Test Plan:
Bench parameters for all scenarios: SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=5, CLEAR_CYC=20, PWRUP_CYC=10, CNT_W=8.
1. Init:
   - Stimulus: release rst; no requests.
   - Required: after 10 cycles, four EN pulses of 3 cycles each with LCMData 0x38, 0x0E, 0x01, 0x06 and RS=0. The 0x01 hold is 20 cycles. ready rises after the last hold; LCMRW=0 throughout.
2. Single write:
   - Stimulus: after ready, req1=1, rs1=1, data1=0x41.
   - Required: ack1 pulses once, LCMRS=1, LCMData=0x41, EN high 3 cycles starting 2 cycles after SETUP entry. busy clears 5 cycles after EN falls.
3. Contention:
   - Stimulus: req0 and req1 held high with 0x31/0x32 from the same cycle, each dropping req on its own ack.
   - Required: requester 0 is served first (0x31), then requester 1 (0x32). Acks are never simultaneous.
4. Fairness:
   - Stimulus: both reqs held high for 6 transactions.
   - Required: grants alternate 0,1,0,1,0,1.
5. Clear timing:
   - Stimulus: req0 with rs0=0, data0=0x01.
   - Required: hold lasts 20 cycles. Then send rs0=1, data0=0x01: hold lasts 5 cycles.
6. Mid-cycle reset and early withdrawal:
   - Stimulus: assert rst during PULSE.
   - Required: next cycle LCMEN=0, ready=0, busy=1, and init restarts.
   - Stimulus: raise req0 while busy and drop it before IDLE.
   - Required: no ack0 and no write.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
// Owns a write-only HD44780-style character LCD bus. After reset it waits for
// the panel to power up, sends the init sequence (0x38, 0x0E, 0x01, 0x06, all
// commands), then shares the bus between two requesters round-robin. Every
// accepted byte becomes one timed write: setup with EN low, EN pulse, then an
// execution hold (longer for Clear / Return Home).
//
// state | meaning
// PWRUP | waiting PWRUP_CYC cycles after reset before the first init write
// IDLE  | bus free; accepts a request once ready=1
// SETUP | RS/data driven, EN=0, for SETUP_CYC cycles
// PULSE | EN=1 for PULSE_CYC cycles
// HOLD  | EN=0 while the LCD executes (HOLD_CYC or CLEAR_CYC cycles)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req0/rs0/data0/ack0  requester 0: level request, RS, byte, accept pulse
//   req1/rs1/data1/ack1  requester 1: same as requester 0
//   ready                init sequence done, requests are served
//   busy                 init or a write cycle in progress
//   LCMEN/LCMRS/LCMRW/LCMData  LCD pins (LCMRW tied low)
module lcd_bus_arbiter #(
   parameter int SETUP_CYC = 4,
   parameter int PULSE_CYC = 12,
   parameter int HOLD_CYC  = 2500,
   parameter int CLEAR_CYC = 82000,
   parameter int PWRUP_CYC = 750000,
   parameter int CNT_W     = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       rs0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic       rs1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       ready,
   output logic       busy,
   output logic       LCMEN,
   output logic       LCMRS,
   output logic       LCMRW,
   output logic [7:0] LCMData
);

   typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD} state_t;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);
   localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);

   state_t           state, stateNxt;
   logic [CNT_W-1:0] cnt, cntNxt;
   logic [1:0]       initIdx, initIdxNxt;
   logic             lastGrant, lastGrantNxt;
   logic             readyNxt, busyNxt, ack0Nxt, ack1Nxt;
   logic             enNxt, rsNxt;
   logic [7:0]       dataNxt;
   logic             grant1;
   logic             isClear;
   logic [CNT_W-1:0] holdLast;

   function automatic logic [7:0] initByte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0E;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   // Clear (0x01) and Return Home (0x02/0x03) need the long execution time.
   assign isClear  = !LCMRS && (LCMData == 8'h01 || LCMData == 8'h02 || LCMData == 8'h03);
   assign holdLast = isClear ? CLEAR_LAST : HOLD_LAST;
   assign LCMRW    = 1'b0;

   always_comb begin
      stateNxt     = state;
      cntNxt       = cnt + CNT_W'(1);
      initIdxNxt   = initIdx;
      lastGrantNxt = lastGrant;
      readyNxt     = ready;
      busyNxt      = busy;
      ack0Nxt      = 1'b0;
      ack1Nxt      = 1'b0;
      enNxt        = LCMEN;
      rsNxt        = LCMRS;
      dataNxt      = LCMData;
      // On a tie the requester that did not win last time gets the bus.
      grant1       = req1 && (!req0 || !lastGrant);

      case (state)
         PWRUP: begin
            if (cnt == PWRUP_LAST) begin
               stateNxt = SETUP;
               cntNxt   = '0;
               rsNxt    = 1'b0;
               dataNxt  = initByte(2'd0);
            end
         end
         IDLE: begin
            cntNxt = '0;
            if (ready && (req0 || req1)) begin
               stateNxt     = SETUP;
               busyNxt      = 1'b1;
               lastGrantNxt = grant1;
               if (grant1) begin
                  rsNxt   = rs1;
                  dataNxt = data1;
                  ack1Nxt = 1'b1;
               end else begin
                  rsNxt   = rs0;
                  dataNxt = data0;
                  ack0Nxt = 1'b1;
               end
            end
         end
         SETUP: begin
            if (cnt == SETUP_LAST) begin
               stateNxt = PULSE;
               cntNxt   = '0;
               enNxt    = 1'b1;
            end
         end
         PULSE: begin
            if (cnt == PULSE_LAST) begin
               stateNxt = HOLD;
               cntNxt   = '0;
               enNxt    = 1'b0;
            end
         end
         HOLD: begin
            if (cnt == holdLast) begin
               cntNxt = '0;
               if (ready || initIdx == 2'd3) begin
                  stateNxt = IDLE;
                  readyNxt = 1'b1;
                  busyNxt  = 1'b0;
               end else begin
                  stateNxt   = SETUP;
                  initIdxNxt = initIdx + 2'd1;
                  rsNxt      = 1'b0;
                  dataNxt    = initByte(initIdx + 2'd1);
               end
            end
         end
         default: begin
            stateNxt = PWRUP;
            cntNxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PWRUP;
         cnt       <= '0;
         initIdx   <= 2'd0;
         lastGrant <= 1'b1;
         ready     <= 1'b0;
         busy      <= 1'b1;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         LCMEN     <= 1'b0;
         LCMRS     <= 1'b0;
         LCMData   <= 8'h00;
      end else begin
         state     <= stateNxt;
         cnt       <= cntNxt;
         initIdx   <= initIdxNxt;
         lastGrant <= lastGrantNxt;
         ready     <= readyNxt;
         busy      <= busyNxt;
         ack0      <= ack0Nxt;
         ack1      <= ack1Nxt;
         LCMEN     <= enNxt;
         LCMRS     <= rsNxt;
         LCMData   <= dataNxt;
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Testbench for lcd_bus_arbiter: directed scenarios plus a randomized phase,
// all outputs compared every cycle against a timeline model of the bus.
module tb_lcd_bus_arbiter;

   localparam int S  = 2;
   localparam int P  = 3;
   localparam int H  = 5;
   localparam int C  = 20;
   localparam int PW = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, ready, busy, LCMEN, LCMRS, LCMRW;
   logic [7:0] LCMData;

   always #5 clk = ~clk;

   lcd_bus_arbiter #(
      .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .CLEAR_CYC(C),
      .PWRUP_CYC(PW), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
      .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
      .ready(ready), .busy(busy),
      .LCMEN(LCMEN), .LCMRS(LCMRS), .LCMRW(LCMRW), .LCMData(LCMData)
   );

   int checks = 0;
   int failures = 0;

   // ---------------- timeline model ----------------
   // t counts clock edges since the last reset edge. A write started at
   // edge s shows EN high on samples [s+S, s+S+P) and frees the bus at
   // s+S+P+hold.
   logic [7:0] initTab [4] = '{8'h38, 8'h0E, 8'h01, 8'h06};
   int         t = 0;
   bit         mInWrite = 0, mReady = 0, mLast = 1, mG;
   int         mInitNo = 0, mStart = 0, mEnd = 0;
   bit         eAck0 = 0, eAck1 = 0, eRs = 0;
   logic [7:0] eData = 8'h00;
   bit         chkOn = 0;

   function automatic int holdOf(input bit rs, input logic [7:0] d);
      return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? C : H;
   endfunction

   task automatic startWrite(input bit rs, input logic [7:0] d);
      mInWrite = 1;
      mStart   = t;
      mEnd     = t + S + P + holdOf(rs, d);
      eRs      = rs;
      eData    = d;
   endtask

   initial forever begin
      @(posedge clk);
      eAck0 = 0;
      eAck1 = 0;
      if (rst) begin
         t = 0; mInWrite = 0; mReady = 0; mLast = 1; mInitNo = 0;
         eRs = 0; eData = 8'h00;
      end else begin
         t++;
         if (!mReady && !mInWrite) begin
            if (t == PW) begin
               startWrite(1'b0, initTab[0]);
               mInitNo = 1;
            end
         end else if (mInWrite) begin
            if (t == mEnd) begin
               mInWrite = 0;
               if (!mReady) begin
                  if (mInitNo < 4) begin
                     startWrite(1'b0, initTab[mInitNo]);
                     mInitNo++;
                  end else mReady = 1;
               end
            end
         end else if (req0 || req1) begin
            mG    = (req0 && req1) ? !mLast : req1;
            mLast = mG;
            if (mG) begin startWrite(rs1, data1); eAck1 = 1; end
            else    begin startWrite(rs0, data0); eAck0 = 1; end
         end
      end
   end

   task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
      end
   endtask

   task automatic checkLit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   bit eEn, eBusy;
   initial forever begin
      @(negedge clk);
      if (chkOn) begin
         eEn   = mInWrite && (t >= mStart + S) && (t < mStart + S + P);
         eBusy = mInWrite || !mReady;
         check1("LCMEN",   8'(LCMEN), 8'(eEn));
         check1("LCMRS",   8'(LCMRS), 8'(eRs));
         check1("LCMData", LCMData, eData);
         check1("LCMRW",   8'(LCMRW), 8'h00);
         check1("busy",    8'(busy),  8'(eBusy));
         check1("ready",   8'(ready), 8'(mReady));
         check1("ack0",    8'(ack0),  8'(eAck0));
         check1("ack1",    8'(ack1),  8'(eAck1));
         check1("ack_excl", 8'(ack0 & ack1), 8'h00);
      end
   end

   // ---------------- event observer for literal checks ----------------
   int         riseT[$];
   logic [7:0] riseD[$];
   int         ackWho[$];
   logic [7:0] ackData[$];
   int         fallT = 0, busyFallT = 0, readyT = -1, ackT = 0;
   bit         prevEn = 0, prevBusy = 1, prevReady = 0;
   initial forever begin
      @(negedge clk);
      if (LCMEN === 1'b1 && !prevEn) begin riseT.push_back(t); riseD.push_back(LCMData); end
      if (LCMEN === 1'b0 && prevEn) fallT = t;
      if (busy === 1'b0 && prevBusy) busyFallT = t;
      if (ready === 1'b1 && !prevReady) readyT = t;
      if (ack0 === 1'b1) begin ackWho.push_back(0); ackData.push_back(LCMData); ackT = t; end
      if (ack1 === 1'b1) begin ackWho.push_back(1); ackData.push_back(LCMData); ackT = t; end
      prevEn    = (LCMEN === 1'b1);
      prevBusy  = (busy === 1'b1);
      prevReady = (ready === 1'b1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic waitReady(input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         tick();
         if (ready === 1'b1) break;
      end
      if (i == bound) checkLit("wait_ready_timeout", 0, 1);
   endtask

   task automatic waitIdle(input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         tick();
         if (busy === 1'b0) break;
      end
      if (i == bound) checkLit("wait_idle_timeout", 0, 1);
   endtask

   // Waits for the given requester's ack, then drops its request.
   task automatic waitAck(input int who, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         tick();
         if (who == 0 && ack0 === 1'b1) begin req0 = 0; break; end
         if (who == 1 && ack1 === 1'b1) begin req1 = 0; break; end
      end
      if (i == bound) checkLit("wait_ack_timeout", 0, 1);
   endtask

   int         n;
   int         lit12[4] = '{12, 22, 32, 57};
   logic [7:0] expInit[4] = '{8'h38, 8'h0E, 8'h01, 8'h06};

   initial begin
      // reset for three edges
      tick();
      chkOn = 1;
      tick();
      tick();
      rst = 0;

      // 1. init sequence
      waitReady(300);
      checkLit("init_pulses", riseT.size(), 4);
      for (int i = 0; i < 4 && i < riseT.size(); i++) begin
         checkLit("init_rise_t", riseT[i], lit12[i]);
         checkLit("init_byte", int'(riseD[i]), int'(expInit[i]));
      end
      checkLit("ready_t", readyT, 65);

      // 2. single write
      ackWho.delete(); riseT.delete(); riseD.delete(); ackData.delete();
      tick();
      req1 = 1; rs1 = 1; data1 = 8'h41;
      waitAck(1, 50);
      data1 = 8'h55; rs1 = 0;   // must not affect the write in flight
      waitIdle(100);
      checkLit("single_acks", ackWho.size(), 1);
      if (ackData.size() > 0) checkLit("single_data", int'(ackData[0]), 8'h41);
      if (riseT.size() > 0)   checkLit("single_en_delay", riseT[0] - ackT, 2);
      checkLit("single_busy_after_fall", busyFallT - fallT, 5);

      // 3. contention
      ackWho.delete(); ackData.delete();
      req0 = 1; rs0 = 1; data0 = 8'h31;
      req1 = 1; rs1 = 1; data1 = 8'h32;
      for (int i = 0; i < 200 && (req0 || req1); i++) begin
         tick();
         if (ack0 === 1'b1) req0 = 0;
         if (ack1 === 1'b1) req1 = 0;
      end
      waitIdle(100);
      checkLit("cont_count", ackWho.size(), 2);
      if (ackWho.size() >= 2) begin
         checkLit("cont_first", ackWho[0], 0);
         checkLit("cont_first_data", int'(ackData[0]), 8'h31);
         checkLit("cont_second", ackWho[1], 1);
         checkLit("cont_second_data", int'(ackData[1]), 8'h32);
      end

      // 4. fairness
      ackWho.delete(); ackData.delete();
      req0 = 1; rs0 = 1; data0 = 8'h61;
      req1 = 1; rs1 = 1; data1 = 8'h62;
      n = 0;
      for (int i = 0; i < 400 && n < 6; i++) begin
         tick();
         if (ack0 === 1'b1 || ack1 === 1'b1) begin
            n++;
            data0 = data0 + 8'd1;
            data1 = data1 + 8'd1;
         end
      end
      req0 = 0; req1 = 0;
      waitIdle(100);
      checkLit("fair_count", ackWho.size(), 6);
      for (int i = 0; i < 6 && i < ackWho.size(); i++)
         checkLit("fair_grant", ackWho[i], i % 2);

      // 5. clear timing
      req0 = 1; rs0 = 0; data0 = 8'h01;
      waitAck(0, 50);
      waitIdle(100);
      checkLit("clear_hold", busyFallT - fallT, 20);
      req0 = 1; rs0 = 1; data0 = 8'h01;
      waitAck(0, 50);
      waitIdle(100);
      checkLit("data01_hold", busyFallT - fallT, 5);

      // 6a. reset during PULSE
      req0 = 1; rs0 = 1; data0 = 8'h44;
      waitAck(0, 50);
      for (int i = 0; i < 20 && LCMEN !== 1'b1; i++) tick();
      checkLit("pulse_reached", int'(LCMEN === 1'b1), 1);
      rst = 1;
      tick();
      rst = 0;
      checkLit("rst_en",    int'(LCMEN === 1'b0), 1);
      checkLit("rst_ready", int'(ready === 1'b0), 1);
      checkLit("rst_busy",  int'(busy === 1'b1), 1);
      riseT.delete(); riseD.delete();
      waitReady(300);
      checkLit("reinit_ready_t", readyT, 65);
      checkLit("reinit_pulses", riseT.size(), 4);

      // 6b. early withdrawal while busy
      ackWho.delete();
      tick();
      req1 = 1; rs1 = 1; data1 = 8'h52;
      waitAck(1, 50);
      req0 = 1; rs0 = 1; data0 = 8'h99;
      for (int i = 0; i < 20 && LCMEN !== 1'b1; i++) tick();
      for (int i = 0; i < 20 && LCMEN !== 1'b0; i++) tick();
      tick();
      checkLit("withdraw_while_busy", int'(busy === 1'b1), 1);
      req0 = 0;
      waitIdle(100);
      repeat (10) tick();
      checkLit("withdraw_acks", ackWho.size(), 1);

      // random phase
      for (int i = 0; i < 4000; i++) begin
         tick();
         rst = ($urandom_range(0, 1999) == 0);
         if (req0) begin
            if (ack0 === 1'b1) begin
               if ($urandom_range(0, 3) != 0) req0 = 0;
               rs0 = 1'($urandom_range(0, 1)); data0 = 8'($urandom);
            end else if ($urandom_range(0, 39) == 0) req0 = 0;
            else if ($urandom_range(0, 9) == 0) data0 = 8'($urandom);
         end else if ($urandom_range(0, 5) == 0) begin
            req0 = 1; rs0 = 1'($urandom_range(0, 1));
            data0 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         end
         if (req1) begin
            if (ack1 === 1'b1) begin
               if ($urandom_range(0, 3) != 0) req1 = 0;
               rs1 = 1'($urandom_range(0, 1)); data1 = 8'($urandom);
            end else if ($urandom_range(0, 39) == 0) req1 = 0;
            else if ($urandom_range(0, 9) == 0) data1 = 8'($urandom);
         end else if ($urandom_range(0, 5) == 0) begin
            req1 = 1; rs1 = 1'($urandom_range(0, 1));
            data1 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         end
      end
      rst = 0; req0 = 0; req1 = 0;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
